// File: rtl/switch_arb5.sv
// switch_arb5: round-robin, packet-locking allocator for one output port of
// the 5-port router. It drives the one-hot select of that port's switch5 mux.
// Inputs are ordered local, N, E, S, W. A grant is held for a whole wormhole
// packet and released when the tail flit actually crosses the switch.
//
// Optional feature macro: ARB_BACK2BACK_EN
//   undefined (default): a released port returns to IDLE for one cycle, and
//                        arbitration resumes from there (one bubble per packet).
//   defined:             the next winner is chosen in the same cycle as the
//                        tail transfer, so the grant switches with no bubble.
module switch_arb5 #(
    parameter int NUM_INPUTS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [NUM_INPUTS-1:0] tail,
    input  logic                  out_ready,
    output logic [NUM_INPUTS-1:0] Gnt,
    output logic                  fire,
    output logic                  busy
);

    localparam int IDX_W = $clog2(NUM_INPUTS);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                r_state;
    logic [NUM_INPUTS-1:0] r_gnt;
    logic [IDX_W-1:0]      r_ptr;
    logic                  r_busy;

    logic                  w_fire;
    logic                  w_tailOfGranted;
    logic                  w_release;
    logic                  w_winFound;
    logic [IDX_W-1:0]      w_winIdx;
    logic [NUM_INPUTS-1:0] w_winOneHot;
    logic [IDX_W-1:0]      w_candIdx;

    // While locked r_gnt is one-hot, so masking with it selects req[g] and
    // tail[g]; in IDLE r_gnt is zero, which also keeps fire low there.
    assign w_fire          = (r_state == LOCKED) & (|(r_gnt & req)) & out_ready;
    assign w_tailOfGranted = |(r_gnt & tail);
    assign w_release       = w_fire & w_tailOfGranted;

    // Round-robin pick: scan (ptr+1)%N, (ptr+2)%N ... ptr and take the first
    // requester. The loop runs from the far end so the nearest match wins.
    // While locked, ptr is the granted index, so the same scan serves the
    // back-to-back case with the current owner eligible only last.
    always_comb begin
        w_winFound  = 1'b0;
        w_winIdx    = '0;
        w_winOneHot = '0;
        w_candIdx   = '0;
        for (int k = NUM_INPUTS; k >= 1; k--) begin
            w_candIdx = IDX_W'((int'(r_ptr) + k) % NUM_INPUTS);
            if (req[w_candIdx]) begin
                w_winFound             = 1'b1;
                w_winIdx               = w_candIdx;
                w_winOneHot            = '0;
                w_winOneHot[w_candIdx] = 1'b1;
            end
        end
    end

    // Lock state machine: grant in IDLE, hold through the packet, release on
    // a tail that really transfers; ptr moves only when a new grant is made.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_ptr   <= IDX_W'(NUM_INPUTS - 1);
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_winFound) begin
                        r_state <= LOCKED;
                        r_gnt   <= w_winOneHot;
                        r_ptr   <= w_winIdx;
                        r_busy  <= 1'b1;
                    end else begin
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (w_release) begin
`ifdef ARB_BACK2BACK_EN
                        if (w_winFound) begin
                            r_state <= LOCKED;
                            r_gnt   <= w_winOneHot;
                            r_ptr   <= w_winIdx;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_gnt   <= '0;
                            r_busy  <= 1'b0;
                        end
`else
                        r_state <= IDLE;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Gnt  = r_gnt;
    assign fire = w_fire;
    assign busy = r_busy;

endmodule

// File: tb/tb_switch_arb5.sv
// tb_switch_arb5: table-driven directed vectors, a hand-written asynchronous
// reset sequence, and randomized traffic checked against a behavioural model
// of the round-robin packet-locking rules. Expectations follow the build's
// ARB_BACK2BACK_EN setting.
module tb_switch_arb5;

    logic       clk;
    logic       rst_n;
    logic [4:0] req;
    logic [4:0] tail;
    logic       out_ready;
    logic [4:0] Gnt;
    logic       fire;
    logic       busy;

    int errors;
    int checks;

    switch_arb5 #(.NUM_INPUTS(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .tail      (tail),
        .out_ready (out_ready),
        .Gnt       (Gnt),
        .fire      (fire),
        .busy      (busy)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        logic [4:0] req;
        logic [4:0] tail;
        logic       ord;
        logic [4:0] expGnt;
        logic       expFire;
        logic       expBusy;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: lock flag, granted index, last-granted pointer
    bit mLocked;
    int mG;
    int mPtr;

    function automatic vec_t mk(bit rst, logic [4:0] r, logic [4:0] t, logic o,
                                logic [4:0] g, logic f, logic b);
        vec_t v;
        v.rst = rst; v.req = r; v.tail = t; v.ord = o;
        v.expGnt = g; v.expFire = f; v.expBusy = b;
        return v;
    endfunction

    function automatic void modelReset();
        mLocked = 1'b0;
        mG      = 0;
        mPtr    = 4;
    endfunction

    // First requester in the order (from+1)%5, (from+2)%5 ... from, or -1
    function automatic int rrScan(logic [4:0] r, int from);
        for (int k = 1; k <= 5; k++) begin
            int idx;
            idx = (from + k) % 5;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [4:0] modelGnt();
        logic [4:0] v;
        v = '0;
        if (mLocked) v[mG] = 1'b1;
        return v;
    endfunction

    function automatic logic modelFire(logic [4:0] r, logic o);
        return mLocked && r[mG] && o;
    endfunction

    function automatic void modelStep(logic [4:0] r, logic [4:0] t, logic o);
        int w;
        if (!mLocked) begin
            w = rrScan(r, mPtr);
            if (w >= 0) begin
                mLocked = 1'b1;
                mG      = w;
                mPtr    = w;
            end
        end else if (modelFire(r, o) && t[mG]) begin
`ifdef ARB_BACK2BACK_EN
            w = rrScan(r, mG);
            if (w >= 0) begin
                mG   = w;
                mPtr = w;
            end else begin
                mLocked = 1'b0;
            end
`else
            mLocked = 1'b0;
`endif
        end
    endfunction

    task automatic cmp(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        req       = '0;
        tail      = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        modelReset();
    endtask

    task automatic applyStimulus(input logic [4:0] r, input logic [4:0] t, input logic o);
        @(negedge clk);
        req       = r;
        tail      = t;
        out_ready = o;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [4:0] g, input logic f, input logic b);
        cmp({tag, " Gnt"}, Gnt, g);
        cmp({tag, " fire"}, {4'b0, fire}, {4'b0, f});
        cmp({tag, " busy"}, {4'b0, busy}, {4'b0, b});
    endtask

    initial begin
        errors = 0;
        checks = 0;
        modelReset();
        doReset();

        // Round-robin order with tail on every flit, req = 10110 held
        vecs.push_back(mk(1, 5'b10110, 5'b11111, 1, 5'b00000, 0, 0));
`ifdef ARB_BACK2BACK_EN
        vecs.push_back(mk(0, 5'b10110, 5'b11111, 1, 5'b00010, 1, 1));
        vecs.push_back(mk(0, 5'b10110, 5'b11111, 1, 5'b00100, 1, 1));
        vecs.push_back(mk(0, 5'b10110, 5'b11111, 1, 5'b10000, 1, 1));
        vecs.push_back(mk(0, 5'b10110, 5'b11111, 1, 5'b00010, 1, 1));
`else
        vecs.push_back(mk(0, 5'b10110, 5'b11111, 1, 5'b00010, 1, 1));
        vecs.push_back(mk(0, 5'b10110, 5'b11111, 1, 5'b00000, 0, 0));
        vecs.push_back(mk(0, 5'b10110, 5'b11111, 1, 5'b00100, 1, 1));
        vecs.push_back(mk(0, 5'b10110, 5'b11111, 1, 5'b00000, 0, 0));
        vecs.push_back(mk(0, 5'b10110, 5'b11111, 1, 5'b10000, 1, 1));
        vecs.push_back(mk(0, 5'b10110, 5'b11111, 1, 5'b00000, 0, 0));
        vecs.push_back(mk(0, 5'b10110, 5'b11111, 1, 5'b00010, 1, 1));
`endif
        // 3-flit packet on input 0 with out_ready pattern 1,0,1,1
        vecs.push_back(mk(1, 5'b00001, 5'b00000, 1, 5'b00000, 0, 0));
        vecs.push_back(mk(0, 5'b00001, 5'b00000, 1, 5'b00001, 1, 1));
        vecs.push_back(mk(0, 5'b00001, 5'b00000, 0, 5'b00001, 0, 1));
        vecs.push_back(mk(0, 5'b00001, 5'b00000, 1, 5'b00001, 1, 1));
        vecs.push_back(mk(0, 5'b00001, 5'b00001, 1, 5'b00001, 1, 1));
`ifdef ARB_BACK2BACK_EN
        vecs.push_back(mk(0, 5'b00000, 5'b00000, 1, 5'b00001, 0, 1));
        vecs.push_back(mk(0, 5'b00000, 5'b00000, 1, 5'b00001, 0, 1));
`else
        vecs.push_back(mk(0, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0));
        vecs.push_back(mk(0, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0));
`endif
        // Input 3 drops req for two cycles while input 1 waits
        vecs.push_back(mk(1, 5'b01000, 5'b00000, 1, 5'b00000, 0, 0));
        vecs.push_back(mk(0, 5'b01010, 5'b00000, 1, 5'b01000, 1, 1));
        vecs.push_back(mk(0, 5'b00010, 5'b00000, 1, 5'b01000, 0, 1));
        vecs.push_back(mk(0, 5'b00010, 5'b00000, 1, 5'b01000, 0, 1));
        vecs.push_back(mk(0, 5'b01010, 5'b01000, 1, 5'b01000, 1, 1));
`ifdef ARB_BACK2BACK_EN
        vecs.push_back(mk(0, 5'b00010, 5'b00010, 0, 5'b00010, 0, 1));
`else
        vecs.push_back(mk(0, 5'b00010, 5'b00010, 0, 5'b00000, 0, 0));
`endif
        vecs.push_back(mk(0, 5'b00010, 5'b00010, 0, 5'b00010, 0, 1));
        vecs.push_back(mk(0, 5'b00010, 5'b00010, 1, 5'b00010, 1, 1));
`ifdef ARB_BACK2BACK_EN
        // Inputs 0 and 4 stream single-flit packets
        vecs.push_back(mk(1, 5'b10001, 5'b10001, 1, 5'b00000, 0, 0));
        vecs.push_back(mk(0, 5'b10001, 5'b10001, 1, 5'b00001, 1, 1));
        vecs.push_back(mk(0, 5'b10001, 5'b10001, 1, 5'b10000, 1, 1));
        vecs.push_back(mk(0, 5'b10001, 5'b10001, 1, 5'b00001, 1, 1));
        vecs.push_back(mk(0, 5'b10001, 5'b10001, 1, 5'b10000, 1, 1));
        // Sole requester 2 keeps the grant with no bubble
        vecs.push_back(mk(1, 5'b00100, 5'b00100, 1, 5'b00000, 0, 0));
        vecs.push_back(mk(0, 5'b00100, 5'b00100, 1, 5'b00100, 1, 1));
        vecs.push_back(mk(0, 5'b00100, 5'b00100, 1, 5'b00100, 1, 1));
        vecs.push_back(mk(0, 5'b00100, 5'b00100, 1, 5'b00100, 1, 1));
`else
        // Sole requester 2 with single-flit packets: one bubble per packet
        vecs.push_back(mk(1, 5'b00100, 5'b00100, 1, 5'b00000, 0, 0));
        vecs.push_back(mk(0, 5'b00100, 5'b00100, 1, 5'b00100, 1, 1));
        vecs.push_back(mk(0, 5'b00100, 5'b00100, 1, 5'b00000, 0, 0));
        vecs.push_back(mk(0, 5'b00100, 5'b00100, 1, 5'b00100, 1, 1));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) doReset();
            applyStimulus(vecs[i].req, vecs[i].tail, vecs[i].ord);
            checkOutput($sformatf("vec%0d", i), vecs[i].expGnt, vecs[i].expFire, vecs[i].expBusy);
        end

        // Asynchronous reset in the middle of a locked packet
        doReset();
        applyStimulus(5'b01000, 5'b00000, 1'b1);
        checkOutput("arst pre", 5'b00000, 1'b0, 1'b0);
        applyStimulus(5'b01000, 5'b00000, 1'b0);
        checkOutput("arst locked", 5'b01000, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst asserted", 5'b00000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n     = 1'b1;
        req       = 5'b11111;
        tail      = 5'b00000;
        out_ready = 1'b0;
        #1;
        checkOutput("arst released", 5'b00000, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("arst regrant", 5'b00001, 1'b0, 1'b1);

        // Randomized traffic against the behavioural model
        doReset();
        for (int n = 0; n < 600; n++) begin
            logic [4:0] r;
            logic [4:0] t;
            logic       o;
            r = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 5) == 0) r = '0;
            t = '0;
            for (int b = 0; b < 5; b++) t[b] = ($urandom_range(0, 2) == 0);
            o = ($urandom_range(0, 3) != 0);
            applyStimulus(r, t, o);
            checkOutput($sformatf("rand%0d", n), modelGnt(), modelFire(r, o), mLocked);
            modelStep(r, t, o);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/switch_arb5.md
# switch_arb5

Round-robin, packet-locking allocator for one output port of the 5-port router. It produces the one-hot `Gnt` that drives that port's `switch5` data mux. It arbitrates among the five input ports (local, N, E, S, W order per `define.vh`), holds the grant for a whole wormhole packet until the tail flit transfers, then rotates priority. Each router output port has one instance.

## Interface
- `NUM_INPUTS`, 5: number of requesting input ports; fixed at 5, must match the width of `Gnt` on `switch5`.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input 5: per-input request; bit i high means input i has a flit for this output.
- `tail` input 5: bit i high means input i's current flit is the packet tail; ignored unless `req[i]` is high.
- `out_ready` input 1: downstream can accept a flit this cycle (credit available).
- `Gnt` output 5: registered one-hot grant to `switch5`; all-zero when idle.
- `fire` output 1: combinational; high when a flit crosses the switch this cycle.
- `busy` output 1: registered; high while a packet holds the lock.

## Operation
- State: `IDLE` / `LOCKED`; `ptr[2:0]` holds the index of the last granted input.
- Reset values: `Gnt`=5'b00000, `busy`=0, state `IDLE`, `ptr`=4. The first arbitration after reset therefore favours input 0.
- `IDLE`:
  - If `req`≠0, select the first set bit scanning (ptr+1)%5, (ptr+2)%5 … ptr.
  - Load its one-hot into `Gnt`, set `ptr` to its index, go to `LOCKED`.
  - `out_ready` is not required to grant.
  - If `req`=0, stay in `IDLE` with `Gnt`=0.
- `LOCKED`:
  - `Gnt` is held constant.
  - `fire` = `req[g] & out_ready`, where g is the granted index.
  - Other inputs' `req` are ignored.
- Release: when `fire & tail[g]`, leave `LOCKED` (see Configuration for what follows).
- If the granted input deasserts `req` mid-packet, the lock holds and `fire`=0; the grant is not revoked.
- A tail with `out_ready`=0 does not release; the release waits until it actually transfers.
- `Gnt` is never multi-hot; `fire` is never high in `IDLE`.
- `busy` equals (state==`LOCKED`).
- Reset asserted mid-packet: immediate asynchronous return to reset values. The in-flight packet is abandoned; upstream recovery is outside this block.

## Timing
- Arbitration latency: `req` seen in `IDLE` at cycle n → `Gnt` valid at cycle n+1.
- `fire` is same-cycle with `req`/`out_ready` while locked, giving one flit per cycle at full throughput.
- Release on tail fire at cycle n → new `Gnt` value at cycle n+1 (0, or the next winner; see Configuration).
- `ptr` updates only on a new grant, never on release.
- Single-flit packet (head=tail): grant at n+1, fire and release possible at n+1.

## Configuration
- `ARB_BACK2BACK_EN`:
  - Defined: on tail fire at cycle n, the next winner is arbitrated in the same cycle from `req`, scanning from (g+1)%5. Input g is eligible only last, so it wins only if it is the sole requester. `Gnt` switches directly to the new one-hot at n+1 with no bubble. If no other request exists and `req[g]` drops, `Gnt`=0 and state goes to `IDLE`.
  - Undefined: tail fire at n gives `Gnt`=0 and `IDLE` at n+1, and arbitration resumes from n+1. This costs a one-cycle bubble per packet.

## Test plan
- Reset then `req`=5'b10110 held, `out_ready`=1, tail on every flit → grants in order 5'b00010, 5'b00100, 5'b10000, 5'b00010; with the macro undefined, `Gnt`=0 between each.
- `req`=5'b00001, 3-flit packet, `out_ready` pattern 1,0,1,1 → `fire` 1,0,1,1; `Gnt` stays 5'b00001 until the cycle after the tail fires.
- Granted input 3 drops `req` for 2 cycles mid-packet while input 1 requests → `Gnt` stays 5'b01000 and `fire`=0; input 1 is granted only after input 3's tail.
- `rst_n` pulsed low asynchronously mid-packet → `Gnt`=0 and `busy`=0 immediately; next `req`=5'b11111 grants 5'b00001.
- With `ARB_BACK2BACK_EN`: inputs 0 and 4 stream single-flit packets → `Gnt` alternates 5'b00001 and 5'b10000 every cycle, with `fire`=1 continuously.
- `req`=5'b00100 alone, single-flit packets back-to-back with the macro defined → `Gnt` stays 5'b00100 and `fire`=1 every cycle.
